bus_capture_fifo: RTL

- Receive-side counterpart to the tristate octal bus register.
- Samples the shared 8-bit data bus on a rising CLK edge whenever the device's active-low read strobe is asserted, and buffers the captured bytes in a small show-ahead FIFO for a downstream consumer.
- Flags bus contention or undriven (floating) bits seen at capture time, so a mis-sequenced output enable is caught in simulation.

---
 rtl/bus_capture_fifo_pkg.sv | 45 ++++
 rtl/bus_capture_mem.sv | 27 ++
 rtl/bus_capture_fifo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bus_capture_fifo_pkg.sv
// Shared bus-device definitions: bus width, operation decode and helper functions.
`ifndef BUS_CAPTURE_FIFO_PKG_SV
`define BUS_CAPTURE_FIFO_PKG_SV

`define BUS_W 8

package bus_capture_fifo_pkg;

    localparam int unsigned BUS_W = `BUS_W;

    typedef logic [BUS_W-1:0] bus_byte_t;

    // Per-edge FIFO operation, encoded as {pop, push}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_SWAP = 2'b11
    } fifo_op_e;

    // Ceiling log2 usable in constant expressions (v >= 1).
    function automatic int unsigned clog2_int(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Any bit that is not a clean 1 (0, z or x) is stored as 0.
    function automatic bus_byte_t sanitize(input bus_byte_t b);
        bus_byte_t s;
        s = '0;
        for (int unsigned i = 0; i < BUS_W; i++) begin
            s[i] = (b[i] === 1'b1);
        end
        return s;
    endfunction

endpackage

`endif

// File: rtl/bus_capture_mem.sv
// DEPTH x BUS_W register array: synchronous write, asynchronous read.
module bus_capture_mem
    import bus_capture_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [BUS_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [BUS_W-1:0] rdata
);

    logic [BUS_W-1:0] mem_q [DEPTH];

    // Write port: store one byte per enabled edge; contents need no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/bus_capture_fifo.sv
// Bus capture FIFO: samples BUS on posedge CLK while _RD is low and buffers
// the bytes in a show-ahead FIFO; flags overflow and floating bus bits.
module bus_capture_fifo
    import bus_capture_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter bit          LOG   = 1'b0
) (
    input  logic                       CLK,
    input  logic                       MR,
    input  logic                       _RD,
    input  logic [BUS_W-1:0]           BUS,
    input  logic                       POP,
    output logic [BUS_W-1:0]           Q,
    output logic                       EMPTY,
    output logic                       FULL,
    output logic [clog2_int(DEPTH):0]  COUNT,
    output logic                       OVF,
    output logic                       FLOAT
);

    localparam int unsigned AW = clog2_int(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             float_q, float_d;

    logic             empty, full;
    logic             cap_req, do_push, do_pop, overflow, bus_unknown;
    logic [BUS_W-1:0] wdata, rdata;
    fifo_op_e         op;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Decode the edge's operation; POP on an empty FIFO never bypasses.
    always_comb begin
        cap_req     = !_RD;
        do_push     = cap_req && (!full || POP);
        do_pop      = POP && !empty;
        overflow    = cap_req && full && !POP;
        bus_unknown = $isunknown(BUS);
        wdata       = sanitize(BUS);
        op          = OP_IDLE;
        unique case ({do_pop, do_push})
            2'b01:   op = OP_PUSH;
            2'b10:   op = OP_POP;
            2'b11:   op = OP_SWAP;
            default: op = OP_IDLE;
        endcase
    end

    // Next-state for pointers, occupancy and sticky flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q | overflow;
        float_d = float_q | (do_push & bus_unknown);
        unique case (op)
            OP_PUSH: begin
                wptr_d  = wptr_q + 1'b1;
                count_d = count_q + 1'b1;
            end
            OP_POP: begin
                rptr_d  = rptr_q + 1'b1;
                count_d = count_q - 1'b1;
            end
            OP_SWAP: begin
                wptr_d = wptr_q + 1'b1;
                rptr_d = rptr_q + 1'b1;
            end
            default: ;
        endcase
    end

    // State register; MR overrides capture and pop on the same edge.
    always_ff @(posedge CLK) begin
        if (MR) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            float_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            float_q <= float_d;
        end
    end

    bus_capture_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (CLK),
        .we    (do_push && !MR),
        .waddr (wptr_q),
        .wdata (wdata),
        .raddr (rptr_q),
        .rdata (rdata)
    );

    assign Q     = empty ? '0 : rdata;
    assign EMPTY = empty;
    assign FULL  = full;
    assign COUNT = count_q;
    assign OVF   = ovf_q;
    assign FLOAT = float_q;

`ifndef SYNTHESIS
    generate
        if (LOG) begin : g_log
            // Simulation trace of captures, pops and first flag assertions.
            always_ff @(posedge CLK) begin
                if (!MR) begin
                    if (do_push) $display("%9t %m CAPTURE %08b", $time, wdata);
                    if (do_pop) $display("%9t %m POP %02h", $time, rdata);
                    if (overflow && !ovf_q) $display("%9t %m OVF set", $time);
                    if (do_push && bus_unknown && !float_q) $display("%9t %m FLOAT set", $time);
                end
            end
        end
    endgenerate
`endif

endmodule
